motor_syn_integrator: RTL and testbench

Consumer end of the synaptic edge stream produced by the fan-out walker. It accepts (dst_id, weight, addr, last) edges through a valid/ready handshake and integrates the weights into membrane potentials for the 4 motor neurons (IDs N_NEURON-4..N_NEURON-1). On each global tick it applies leak, threshold and refractory handling to the 4 neurons. It then emits the resulting motor spikes one at a time through a second valid/ready handshake.

---
 rtl/snn_pkg.sv | 39 +++
 rtl/motor_neuron_lane.sv | 46 ++++
 rtl/motor_syn_integrator.sv | 144 ++++++++++++++
 tb/tb_motor_syn_integrator.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types, sizes and helpers for the motor synapse integrator
package snn_pkg;
    localparam int N_NEURON       = 64;
    localparam int NEURON_ID_W    = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
    localparam int TOTAL_SYNAPSES = 4096;
    localparam int SYN_ADDR_W     = (TOTAL_SYNAPSES > 1) ? $clog2(TOTAL_SYNAPSES) : 1;
    localparam int WEIGHT_W       = 16;
    localparam int VMEM_W         = 24;
    localparam int N_MOTOR        = 4;
    localparam int MOTOR_BASE     = N_NEURON - N_MOTOR;

    typedef logic [1:0]                   motor_idx_t;
    typedef logic [NEURON_ID_W-1:0]       neuron_id_t;
    typedef logic signed [VMEM_W-1:0]     vmem_t;
    typedef logic signed [WEIGHT_W-1:0]   weight_t;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        LEAK  = 2'd1,
        EMIT  = 2'd2
    } fsm_state_e;

    function automatic logic is_motor(neuron_id_t id);
        return id >= neuron_id_t'(MOTOR_BASE);
    endfunction

    function automatic neuron_id_t motor_id(motor_idx_t idx);
        return neuron_id_t'(MOTOR_BASE) + neuron_id_t'(idx);
    endfunction

    // One guard bit catches overflow; clamp towards the sign of the true sum.
    function automatic vmem_t sat_add(vmem_t a, weight_t w);
        logic [VMEM_W:0] s;
        s = {a[VMEM_W-1], a} + {{(VMEM_W+1-WEIGHT_W){w[WEIGHT_W-1]}}, w};
        if (s[VMEM_W] != s[VMEM_W-1])
            return s[VMEM_W] ? {1'b1, {(VMEM_W-1){1'b0}}} : {1'b0, {(VMEM_W-1){1'b1}}};
        return s[VMEM_W-1:0];
    endfunction
endpackage

// File: rtl/motor_neuron_lane.sv
// rtl/motor_neuron_lane.sv - one motor neuron: membrane and refractory state with add/leak/fire
module motor_neuron_lane
    import snn_pkg::*;
#(
    parameter int THRESH       = 256,
    parameter int LEAK_SHIFT   = 4,
    parameter int REFRAC_TICKS = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clk_en,
    input  logic    add_en,
    input  weight_t weight,
    input  logic    leak_en,
    output logic    fire,
    output vmem_t   vmem
);
    logic [3:0] refrac;
    logic       ready_n;
    vmem_t      leaked;

    assign ready_n = (refrac != 4'd0);
    assign leaked  = vmem - (vmem >>> LEAK_SHIFT);
    assign fire    = leak_en && !ready_n && (leaked >= vmem_t'(THRESH));

    // Edges landing during refractory time are discarded, not queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vmem   <= '0;
            refrac <= 4'd0;
        end else if (clk_en) begin
            if (leak_en) begin
                if (ready_n) begin
                    refrac <= refrac - 4'd1;
                end else if (fire) begin
                    vmem   <= '0;
                    refrac <= 4'(REFRAC_TICKS);
                end else begin
                    vmem <= leaked;
                end
            end else if (add_en && !ready_n) begin
                vmem <= sat_add(vmem, weight);
            end
        end
    end
endmodule

// File: rtl/motor_syn_integrator.sv
// rtl/motor_syn_integrator.sv - integrates synaptic edges into 4 motor neurons and emits their spikes
module motor_syn_integrator #(
    parameter int N_NEURON       = snn_pkg::N_NEURON,
    parameter int NEURON_ID_W    = (N_NEURON > 1) ? $clog2(N_NEURON) : 1,
    parameter int TOTAL_SYNAPSES = snn_pkg::TOTAL_SYNAPSES,
    parameter int SYN_ADDR_W     = (TOTAL_SYNAPSES > 1) ? $clog2(TOTAL_SYNAPSES) : 1,
    parameter int WEIGHT_W       = snn_pkg::WEIGHT_W,
    parameter int VMEM_W         = snn_pkg::VMEM_W,
    parameter int THRESH         = 256,
    parameter int LEAK_SHIFT     = 4,
    parameter int REFRAC_TICKS   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NEURON_ID_W-1:0] in_dst_id,
    input  logic [WEIGHT_W-1:0]    in_weight,
    input  logic [SYN_ADDR_W-1:0]  in_addr,
    input  logic                   in_last,
    input  logic                   tick_i,
    output logic                   spike_valid_o,
    input  logic                   spike_ready_i,
    output logic [NEURON_ID_W-1:0] spike_id_o,
    output logic [4*VMEM_W-1:0]    vmem_o,
    output logic                   busy_o,
    output logic                   err_dst_o,
    output logic                   tick_ovr_o
);
    import snn_pkg::*;

    localparam logic [1:0] ST_ACCUM = ACCUM;
    localparam logic [1:0] ST_LEAK  = LEAK;
    localparam logic [1:0] ST_EMIT  = EMIT;

    logic [1:0] state;
    motor_idx_t leak_idx;
    logic       tick_pend;
    logic       in_pkt;
    logic [3:0] spike_mask;
    logic       err_dst;
    logic       tick_ovr;

    logic       accept;
    logic       dst_motor;
    motor_idx_t dst_idx;
    logic       in_pkt_nxt;
    logic       go_leak;
    motor_idx_t spike_idx;
    logic [3:0] mask_next;
    logic [3:0] add_en;
    logic [3:0] leak_en;
    logic [3:0] fire;
    vmem_t      vmem [4];
    logic       unused_addr;

    assign unused_addr = ^in_addr;

    // A pending tick only blocks new edges once the open packet has closed.
    assign in_ready   = clk_en && (state == ST_ACCUM) && !(tick_pend && !in_pkt);
    assign accept     = in_valid && in_ready;
    assign dst_motor  = is_motor(neuron_id_t'(in_dst_id));
    assign dst_idx    = motor_idx_t'(neuron_id_t'(in_dst_id) - motor_id(2'd0));
    assign in_pkt_nxt = accept ? !in_last : in_pkt;
    assign go_leak    = (state == ST_ACCUM) && (tick_pend || tick_i) && !in_pkt_nxt;

    always_comb begin
        spike_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (spike_mask[i]) spike_idx = motor_idx_t'(i);
        end
    end

    assign mask_next     = spike_mask & ~(4'b0001 << spike_idx);
    assign spike_valid_o = (state == ST_EMIT);
    assign spike_id_o    = NEURON_ID_W'(motor_id(spike_idx));
    assign busy_o        = (state != ST_ACCUM);
    assign err_dst_o     = err_dst;
    assign tick_ovr_o    = tick_ovr;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign add_en[k]  = accept && dst_motor && (dst_idx == motor_idx_t'(k));
        assign leak_en[k] = (state == ST_LEAK) && (leak_idx == motor_idx_t'(k));

        motor_neuron_lane #(
            .THRESH       (THRESH),
            .LEAK_SHIFT   (LEAK_SHIFT),
            .REFRAC_TICKS (REFRAC_TICKS)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clk_en  (clk_en),
            .add_en  (add_en[k]),
            .weight  (weight_t'(in_weight)),
            .leak_en (leak_en[k]),
            .fire    (fire[k]),
            .vmem    (vmem[k])
        );

        assign vmem_o[k*VMEM_W +: VMEM_W] = vmem[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ACCUM;
            leak_idx   <= 2'd0;
            tick_pend  <= 1'b0;
            in_pkt     <= 1'b0;
            spike_mask <= 4'd0;
            err_dst    <= 1'b0;
            tick_ovr   <= 1'b0;
        end else if (clk_en) begin
            in_pkt <= in_pkt_nxt;
            if (accept && !dst_motor) err_dst <= 1'b1;
            if (tick_i && (tick_pend || state != ST_ACCUM)) tick_ovr <= 1'b1;
            // Extra ticks coalesce into the one that starts the next leak pass.
            if (go_leak) tick_pend <= 1'b0;
            else if (tick_i) tick_pend <= 1'b1;

            case (state)
                ST_ACCUM: begin
                    if (go_leak) begin
                        state    <= ST_LEAK;
                        leak_idx <= 2'd0;
                    end
                end
                ST_LEAK: begin
                    spike_mask <= spike_mask | fire;
                    leak_idx   <= leak_idx + 2'd1;
                    if (leak_idx == 2'd3)
                        state <= ((spike_mask | fire) != 4'd0) ? ST_EMIT : ST_ACCUM;
                end
                ST_EMIT: begin
                    if (spike_ready_i) begin
                        spike_mask <= mask_next;
                        if (mask_next == 4'd0) state <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_motor_syn_integrator.sv
// tb/tb_motor_syn_integrator.sv - self-checking bench for motor_syn_integrator
module tb_motor_syn_integrator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_dst_id = '0;
    logic [15:0] in_weight = '0;
    logic [11:0] in_addr = '0;
    logic        in_last = 1'b0;
    logic        tick_i = 1'b0;
    logic        spike_valid_o;
    logic        spike_ready_i = 1'b0;
    logic [5:0]  spike_id_o;
    logic [95:0] vmem_o;
    logic        busy_o;
    logic        err_dst_o;
    logic        tick_ovr_o;

    int checks = 0;
    int failures = 0;
    logic [5:0] exp_q[$];

    motor_syn_integrator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_en        (clk_en),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dst_id     (in_dst_id),
        .in_weight     (in_weight),
        .in_addr       (in_addr),
        .in_last       (in_last),
        .tick_i        (tick_i),
        .spike_valid_o (spike_valid_o),
        .spike_ready_i (spike_ready_i),
        .spike_id_o    (spike_id_o),
        .vmem_o        (vmem_o),
        .busy_o        (busy_o),
        .err_dst_o     (err_dst_o),
        .tick_ovr_o    (tick_ovr_o)
    );

    always #5 clk = ~clk;

    function automatic logic signed [23:0] vm(input int k);
        return vmem_o[k*24 +: 24];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; tick_i = 1'b0; spike_ready_i = 1'b0; clk_en = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_edge(input int dst, input int w, input logic last);
        int n = 0;
        in_valid = 1'b1; in_dst_id = 6'(dst); in_weight = 16'(w); in_last = last;
        in_addr = 12'($urandom_range(0, 4095));
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL edge_accept dst=%0d ready=%b required=1", dst, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        tick_i = 1'b1;
        @(negedge clk);
        tick_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy_o || spike_valid_o) && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_timeout busy=%b required=0", tag, busy_o);
        end
    endtask

    task automatic drain_spikes(input string tag);
        int n = 0;
        logic [5:0] e;
        spike_ready_i = 1'b1;
        while ((exp_q.size() > 0 || busy_o) && n < 60) begin
            if (spike_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_spike id=%0d required=none", tag, spike_id_o);
                end else begin
                    e = exp_q.pop_front();
                    if (spike_id_o !== e) begin
                        failures++;
                        $display("FAIL %s spike_id got=%0d required=%0d", tag, spike_id_o, e);
                    end
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_spikes left=%0d required=0", tag, exp_q.size());
            exp_q.delete();
        end
        spike_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (spike_valid_o !== 1'b0) begin failures++; $display("FAIL rst_spike_valid got=%b required=0", spike_valid_o); end
        if (spike_id_o !== 6'd60) begin failures++; $display("FAIL rst_spike_id got=%0d required=60", spike_id_o); end
        if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b required=0", busy_o); end
        if (err_dst_o !== 1'b0) begin failures++; $display("FAIL rst_err_dst got=%b required=0", err_dst_o); end
        if (tick_ovr_o !== 1'b0) begin failures++; $display("FAIL rst_tick_ovr got=%b required=0", tick_ovr_o); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (vm(k) !== 24'sd0) begin failures++; $display("FAIL rst_vmem%0d got=%0d required=0", k, vm(k)); end
        end
        clk_en = 1'b0;
        tick_i = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL freeze_in_ready got=%b required=0", in_ready); end
        @(negedge clk);
        tick_i = 1'b0;
        clk_en = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL freeze_tick_ignored busy=%b required=0", busy_o); end
    endtask

    task automatic test_leak_no_spike();
        int busy_cnt = 0;
        int spk = 0;
        do_reset();
        for (int k = 0; k < 4; k++) send_edge(60 + k, 64, k == 3);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (vm(k) !== 24'sd64) begin failures++; $display("FAIL leak_pre_vmem%0d got=%0d required=64", k, vm(k)); end
        end
        tick_i = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) tick_i = 1'b0;
            if (busy_o) busy_cnt++;
            if (spike_valid_o) spk++;
        end
        checks += 2;
        if (busy_cnt != 4) begin failures++; $display("FAIL leak_busy_cycles got=%0d required=4", busy_cnt); end
        if (spk != 0) begin failures++; $display("FAIL leak_spike_cycles got=%0d required=0", spk); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (vm(k) !== 24'sd60) begin failures++; $display("FAIL leak_post_vmem%0d got=%0d required=60", k, vm(k)); end
        end
    endtask

    task automatic test_spike_order();
        int lat = 0;
        do_reset();
        for (int p = 0; p < 5; p++)
            for (int k = 0; k < 4; k++) send_edge(60 + k, 64, k == 3);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (vm(k) !== 24'sd320) begin failures++; $display("FAIL order_pre_vmem%0d got=%0d required=320", k, vm(k)); end
        end
        for (int k = 0; k < 4; k++) exp_q.push_back(6'(60 + k));
        tick_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) tick_i = 1'b0;
            if (spike_valid_o) begin lat = c; break; end
        end
        checks++;
        if (lat != 5) begin failures++; $display("FAIL tick_to_spike_latency got=%0d required=5", lat); end
        for (int c = 0; c < 3; c++) begin
            checks += 2;
            if (spike_valid_o !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%b required=1", c, spike_valid_o); end
            if (spike_id_o !== 6'd60) begin failures++; $display("FAIL hold_id cyc=%0d got=%0d required=60", c, spike_id_o); end
            @(negedge clk);
        end
        drain_spikes("order");
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (vm(k) !== 24'sd0) begin failures++; $display("FAIL order_post_vmem%0d got=%0d required=0", k, vm(k)); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (300) send_edge(60, 32767, 1'b1);
        checks++;
        if (vm(0) !== 24'sd8388607) begin failures++; $display("FAIL sat_pos got=%0d required=8388607", vm(0)); end
        repeat (600) send_edge(60, -32768, 1'b1);
        checks += 2;
        if (vm(0) != -8388608) begin failures++; $display("FAIL sat_neg got=%0d required=-8388608", vm(0)); end
        if (vm(1) !== 24'sd0) begin failures++; $display("FAIL sat_other_lane got=%0d required=0", vm(1)); end
    endtask

    task automatic test_refractory();
        do_reset();
        repeat (5) send_edge(60, 64, 1'b1);
        exp_q.push_back(6'd60);
        pulse_tick();
        drain_spikes("refrac_fire");
        for (int t = 1; t <= 2; t++) begin
            repeat (8) send_edge(60, 64, 1'b1);
            checks++;
            if (vm(0) !== 24'sd0) begin failures++; $display("FAIL refrac_drop tick=%0d got=%0d required=0", t, vm(0)); end
            pulse_tick();
            wait_idle("refrac_tick");
        end
        repeat (8) send_edge(60, 64, 1'b1);
        checks++;
        if (vm(0) !== 24'sd512) begin failures++; $display("FAIL refrac_release got=%0d required=512", vm(0)); end
    endtask

    task automatic test_deferred_tick();
        do_reset();
        send_edge(60, 16, 1'b0);
        send_edge(60, 16, 1'b0);
        pulse_tick();
        checks += 3;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL defer_ready got=%b required=1", in_ready); end
        if (busy_o !== 1'b0) begin failures++; $display("FAIL defer_busy got=%b required=0", busy_o); end
        if (tick_ovr_o !== 1'b0) begin failures++; $display("FAIL defer_ovr_early got=%b required=0", tick_ovr_o); end
        pulse_tick();
        checks++;
        if (tick_ovr_o !== 1'b1) begin failures++; $display("FAIL defer_ovr got=%b required=1", tick_ovr_o); end
        send_edge(60, 16, 1'b0);
        checks += 2;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL defer_ready_mid got=%b required=1", in_ready); end
        if (busy_o !== 1'b0) begin failures++; $display("FAIL defer_busy_mid got=%b required=0", busy_o); end
        send_edge(60, 16, 1'b1);
        checks += 2;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL defer_ready_after_last got=%b required=0", in_ready); end
        if (busy_o !== 1'b1) begin failures++; $display("FAIL defer_leak_start got=%b required=1", busy_o); end
        wait_idle("defer");
        checks++;
        if (vm(0) !== 24'sd60) begin failures++; $display("FAIL defer_vmem got=%0d required=60", vm(0)); end
    endtask

    task automatic test_err_dst_and_reset();
        int n = 0;
        do_reset();
        send_edge(5, 100, 1'b1);
        checks++;
        if (err_dst_o !== 1'b1) begin failures++; $display("FAIL err_dst got=%b required=1", err_dst_o); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (vm(k) !== 24'sd0) begin failures++; $display("FAIL err_vmem%0d got=%0d required=0", k, vm(k)); end
        end
        repeat (5) send_edge(63, 64, 1'b1);
        pulse_tick();
        while (!spike_valid_o && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (spike_id_o !== 6'd63 || spike_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL emit63 id=%0d valid=%b required=63/1", spike_id_o, spike_valid_o);
        end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (spike_valid_o !== 1'b0) begin failures++; $display("FAIL rst_emit_valid got=%b required=0", spike_valid_o); end
        if (err_dst_o !== 1'b0) begin failures++; $display("FAIL rst_emit_err got=%b required=0", err_dst_o); end
        if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_emit_busy got=%b required=0", busy_o); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks += 2;
        if (spike_valid_o !== 1'b0) begin failures++; $display("FAIL lost_spike_valid got=%b required=0", spike_valid_o); end
        if (vm(3) !== 24'sd0) begin failures++; $display("FAIL rst_vmem3 got=%0d required=0", vm(3)); end
    endtask

    initial begin
        test_reset();
        test_leak_no_spike();
        test_spike_order();
        test_saturation();
        test_refractory();
        test_deferred_tick();
        test_err_dst_and_reset();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d required=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
